// File: rtl/mips_instr_encoder.sv
// Purpose : turns symbolic instruction requests (op enum + fields) into 32-bit MIPS words.
// Latency : 1 cycle from accept to out_valid; the LI pseudo-op emits two words on consecutive loads.
// Backpres: in_ready drops while out_valid & ~out_ready (word held stable) and while the LI low half is pending.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready        request handshake; in_op selects the op, in_rs/in_rt/in_rd/in_shamt/in_imm carry fields
//   addr_clr                 restart word-address numbering at 0 (a word loaded in the same cycle gets 0)
//   out_valid/out_ready      encoded-word handshake; out_ins is the word, out_addr its word address
//   err                      one-cycle pulse when an illegal op was accepted and dropped
module mips_instr_encoder #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [31:0]       in_imm,
  input  logic              addr_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_ins,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err
);

  // Op enum values
  localparam logic [5:0] OP_ADD   = 6'd0;
  localparam logic [5:0] OP_ADDU  = 6'd1;
  localparam logic [5:0] OP_SUB   = 6'd2;
  localparam logic [5:0] OP_SUBU  = 6'd3;
  localparam logic [5:0] OP_AND   = 6'd4;
  localparam logic [5:0] OP_OR    = 6'd5;
  localparam logic [5:0] OP_XOR   = 6'd6;
  localparam logic [5:0] OP_NOR   = 6'd7;
  localparam logic [5:0] OP_SLT   = 6'd8;
  localparam logic [5:0] OP_SLTU  = 6'd9;
  localparam logic [5:0] OP_SLL   = 6'd10;
  localparam logic [5:0] OP_SRL   = 6'd11;
  localparam logic [5:0] OP_SRA   = 6'd12;
  localparam logic [5:0] OP_SLLV  = 6'd13;
  localparam logic [5:0] OP_SRLV  = 6'd14;
  localparam logic [5:0] OP_SRAV  = 6'd15;
  localparam logic [5:0] OP_JR    = 6'd16;
  localparam logic [5:0] OP_JALR  = 6'd17;
  localparam logic [5:0] OP_ADDI  = 6'd18;
  localparam logic [5:0] OP_ADDIU = 6'd19;
  localparam logic [5:0] OP_ANDI  = 6'd20;
  localparam logic [5:0] OP_ORI   = 6'd21;
  localparam logic [5:0] OP_XORI  = 6'd22;
  localparam logic [5:0] OP_SLTI  = 6'd23;
  localparam logic [5:0] OP_SLTIU = 6'd24;
  localparam logic [5:0] OP_LUI   = 6'd25;
  localparam logic [5:0] OP_LW    = 6'd26;
  localparam logic [5:0] OP_SW    = 6'd27;
  localparam logic [5:0] OP_LB    = 6'd28;
  localparam logic [5:0] OP_LBU   = 6'd29;
  localparam logic [5:0] OP_SB    = 6'd30;
  localparam logic [5:0] OP_BEQ   = 6'd31;
  localparam logic [5:0] OP_BNE   = 6'd32;
  localparam logic [5:0] OP_BLEZ  = 6'd33;
  localparam logic [5:0] OP_BGTZ  = 6'd34;
  localparam logic [5:0] OP_BLTZ  = 6'd35;
  localparam logic [5:0] OP_BGEZ  = 6'd36;
  localparam logic [5:0] OP_J     = 6'd37;
  localparam logic [5:0] OP_JAL   = 6'd38;
  localparam logic [5:0] OP_LI    = 6'd39;

  // Primary opcodes
  localparam logic [5:0] OPC_SPECIAL = 6'h00;
  localparam logic [5:0] OPC_REGIMM  = 6'h01;
  localparam logic [5:0] OPC_J       = 6'h02;
  localparam logic [5:0] OPC_JAL     = 6'h03;
  localparam logic [5:0] OPC_BEQ     = 6'h04;
  localparam logic [5:0] OPC_BNE     = 6'h05;
  localparam logic [5:0] OPC_BLEZ    = 6'h06;
  localparam logic [5:0] OPC_BGTZ    = 6'h07;
  localparam logic [5:0] OPC_ADDI    = 6'h08;
  localparam logic [5:0] OPC_ADDIU   = 6'h09;
  localparam logic [5:0] OPC_SLTI    = 6'h0A;
  localparam logic [5:0] OPC_SLTIU   = 6'h0B;
  localparam logic [5:0] OPC_ANDI    = 6'h0C;
  localparam logic [5:0] OPC_ORI     = 6'h0D;
  localparam logic [5:0] OPC_XORI    = 6'h0E;
  localparam logic [5:0] OPC_LUI     = 6'h0F;
  localparam logic [5:0] OPC_LB      = 6'h20;
  localparam logic [5:0] OPC_LW      = 6'h23;
  localparam logic [5:0] OPC_LBU     = 6'h24;
  localparam logic [5:0] OPC_SB      = 6'h28;
  localparam logic [5:0] OPC_SW      = 6'h2B;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, LI_LO} state_t;

  state_t              state, state_n;
  logic [31:0]         enc_ins;
  logic                enc_legal;
  logic                enc_li;
  logic                load_free;
  logic                accept;
  logic                load;
  logic [31:0]         load_ins;
  logic [ADDR_W-1:0]   load_addr;
  logic                err_n;
  logic                li_cap;
  logic [ADDR_W-1:0]   next_addr;
  logic [4:0]          li_rt;
  logic [15:0]         li_lo;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] funct);
    return {OPC_SPECIAL, rs, rt, rd, sh, funct};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] opc, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  // Encoder. Fields the decoder expects to be zero are forced to zero here so
  // every emitted word decodes back to the requested op.
  always_comb begin
    enc_ins   = 32'd0;
    enc_legal = 1'b1;
    enc_li    = 1'b0;
    case (in_op)
      OP_ADD:   enc_ins = rtype(in_rs, in_rt, in_rd, 5'd0, 6'h20);
      OP_ADDU:  enc_ins = rtype(in_rs, in_rt, in_rd, 5'd0, 6'h21);
      OP_SUB:   enc_ins = rtype(in_rs, in_rt, in_rd, 5'd0, 6'h22);
      OP_SUBU:  enc_ins = rtype(in_rs, in_rt, in_rd, 5'd0, 6'h23);
      OP_AND:   enc_ins = rtype(in_rs, in_rt, in_rd, 5'd0, 6'h24);
      OP_OR:    enc_ins = rtype(in_rs, in_rt, in_rd, 5'd0, 6'h25);
      OP_XOR:   enc_ins = rtype(in_rs, in_rt, in_rd, 5'd0, 6'h26);
      OP_NOR:   enc_ins = rtype(in_rs, in_rt, in_rd, 5'd0, 6'h27);
      OP_SLT:   enc_ins = rtype(in_rs, in_rt, in_rd, 5'd0, 6'h2A);
      OP_SLTU:  enc_ins = rtype(in_rs, in_rt, in_rd, 5'd0, 6'h2B);
      OP_SLL:   enc_ins = rtype(5'd0, in_rt, in_rd, in_shamt, 6'h00);
      OP_SRL:   enc_ins = rtype(5'd0, in_rt, in_rd, in_shamt, 6'h02);
      OP_SRA:   enc_ins = rtype(5'd0, in_rt, in_rd, in_shamt, 6'h03);
      OP_SLLV:  enc_ins = rtype(in_rs, in_rt, in_rd, 5'd0, 6'h04);
      OP_SRLV:  enc_ins = rtype(in_rs, in_rt, in_rd, 5'd0, 6'h06);
      OP_SRAV:  enc_ins = rtype(in_rs, in_rt, in_rd, 5'd0, 6'h07);
      OP_JR:    enc_ins = rtype(in_rs, 5'd0, 5'd0, 5'd0, 6'h08);
      // JALR always links through r31
      OP_JALR:  enc_ins = rtype(in_rs, 5'd0, 5'd31, 5'd0, 6'h09);
      OP_ADDI:  enc_ins = itype(OPC_ADDI,  in_rs, in_rt, in_imm[15:0]);
      OP_ADDIU: enc_ins = itype(OPC_ADDIU, in_rs, in_rt, in_imm[15:0]);
      OP_ANDI:  enc_ins = itype(OPC_ANDI,  in_rs, in_rt, in_imm[15:0]);
      OP_ORI:   enc_ins = itype(OPC_ORI,   in_rs, in_rt, in_imm[15:0]);
      OP_XORI:  enc_ins = itype(OPC_XORI,  in_rs, in_rt, in_imm[15:0]);
      OP_SLTI:  enc_ins = itype(OPC_SLTI,  in_rs, in_rt, in_imm[15:0]);
      OP_SLTIU: enc_ins = itype(OPC_SLTIU, in_rs, in_rt, in_imm[15:0]);
      OP_LUI:   enc_ins = itype(OPC_LUI,   5'd0,  in_rt, in_imm[15:0]);
      OP_LW:    enc_ins = itype(OPC_LW,    in_rs, in_rt, in_imm[15:0]);
      OP_SW:    enc_ins = itype(OPC_SW,    in_rs, in_rt, in_imm[15:0]);
      OP_LB:    enc_ins = itype(OPC_LB,    in_rs, in_rt, in_imm[15:0]);
      OP_LBU:   enc_ins = itype(OPC_LBU,   in_rs, in_rt, in_imm[15:0]);
      OP_SB:    enc_ins = itype(OPC_SB,    in_rs, in_rt, in_imm[15:0]);
      OP_BEQ:   enc_ins = itype(OPC_BEQ,   in_rs, in_rt, in_imm[15:0]);
      OP_BNE:   enc_ins = itype(OPC_BNE,   in_rs, in_rt, in_imm[15:0]);
      OP_BLEZ:  enc_ins = itype(OPC_BLEZ,  in_rs, 5'd0,  in_imm[15:0]);
      OP_BGTZ:  enc_ins = itype(OPC_BGTZ,  in_rs, 5'd0,  in_imm[15:0]);
      // REGIMM branches are distinguished by the rt field
      OP_BLTZ:  enc_ins = itype(OPC_REGIMM, in_rs, 5'd0, in_imm[15:0]);
      OP_BGEZ:  enc_ins = itype(OPC_REGIMM, in_rs, 5'd1, in_imm[15:0]);
      OP_J:     enc_ins = {OPC_J,   in_imm[25:0]};
      OP_JAL:   enc_ins = {OPC_JAL, in_imm[25:0]};
      // LI emits the LUI half now; the ORI half is built from latched fields later
      OP_LI: begin
        enc_ins = itype(OPC_LUI, 5'd0, in_rt, in_imm[31:16]);
        enc_li  = 1'b1;
      end
      default:  enc_legal = 1'b0;
    endcase
  end

  // Control: handshake, output-register load decision, next state.
  always_comb begin
    load_free = ~out_valid | out_ready;
    in_ready  = (state == IDLE) & load_free;
    accept    = in_valid & in_ready;
    state_n   = state;
    load      = 1'b0;
    load_ins  = enc_ins;
    err_n     = 1'b0;
    li_cap    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!enc_legal) begin
            err_n = 1'b1;
          end else begin
            load = 1'b1;
            if (enc_li) begin
              li_cap  = 1'b1;
              state_n = LI_LO;
            end
          end
        end
      end
      LI_LO: begin
        if (load_free) begin
          load     = 1'b1;
          load_ins = itype(OPC_ORI, li_rt, li_rt, li_lo);
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    load_addr = addr_clr ? '0 : next_addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_ins   <= 32'd0;
      out_addr  <= '0;
      err       <= 1'b0;
      next_addr <= '0;
      li_rt     <= 5'd0;
      li_lo     <= 16'd0;
    end else begin
      state <= state_n;
      err   <= err_n;
      if (load) begin
        out_valid <= 1'b1;
        out_ins   <= load_ins;
        out_addr  <= load_addr;
        next_addr <= load_addr + ADDR_ONE;
      end else begin
        if (out_ready) out_valid <= 1'b0;
        // clear with no load only rewinds numbering; the held word keeps its tag
        if (addr_clr) next_addr <= '0;
      end
      if (li_cap) begin
        li_rt <= in_rt;
        li_lo <= in_imm[15:0];
      end
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
module tb_mips_instr_encoder;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [5:0]    in_op;
  logic [4:0]    in_rs, in_rt, in_rd, in_shamt;
  logic [31:0]   in_imm;
  logic          addr_clr;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_ins;
  logic [AW-1:0] out_addr;
  logic          err;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a queue of words still owed, plus the output slot contents.
  logic [31:0] pend[$];
  logic        m_ovalid;
  logic [31:0] m_oins;
  int          m_oaddr;
  logic        m_err;
  int          m_next;

  mips_instr_encoder #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
    .addr_clr(addr_clr), .out_valid(out_valid), .out_ready(out_ready),
    .out_ins(out_ins), .out_addr(out_addr), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rw(input int rs, input int rt, input int rd, input int sh, input int f);
    return (rs << 21) | (rt << 16) | (rd << 11) | (sh << 6) | f;
  endfunction

  function automatic logic [31:0] iw(input int opc, input int rs, input int rt, input int imm);
    return (opc << 26) | (rs << 21) | (rt << 16) | (imm & 32'hFFFF);
  endfunction

  // Returns how many words the request expands to (0 = illegal).
  function automatic int expand(input int op, input int rs, input int rt, input int rd, input int sh,
                                input logic [31:0] imm, output logic [31:0] w0, output logic [31:0] w1);
    int lo;
    lo = int'(imm & 32'hFFFF);
    w0 = 32'd0;
    w1 = 32'd0;
    case (op)
      0: w0 = rw(rs, rt, rd, 0, 'h20);   1: w0 = rw(rs, rt, rd, 0, 'h21);
      2: w0 = rw(rs, rt, rd, 0, 'h22);   3: w0 = rw(rs, rt, rd, 0, 'h23);
      4: w0 = rw(rs, rt, rd, 0, 'h24);   5: w0 = rw(rs, rt, rd, 0, 'h25);
      6: w0 = rw(rs, rt, rd, 0, 'h26);   7: w0 = rw(rs, rt, rd, 0, 'h27);
      8: w0 = rw(rs, rt, rd, 0, 'h2A);   9: w0 = rw(rs, rt, rd, 0, 'h2B);
      10: w0 = rw(0, rt, rd, sh, 'h00);  11: w0 = rw(0, rt, rd, sh, 'h02);
      12: w0 = rw(0, rt, rd, sh, 'h03);  13: w0 = rw(rs, rt, rd, 0, 'h04);
      14: w0 = rw(rs, rt, rd, 0, 'h06);  15: w0 = rw(rs, rt, rd, 0, 'h07);
      16: w0 = rw(rs, 0, 0, 0, 'h08);    17: w0 = rw(rs, 0, 31, 0, 'h09);
      18: w0 = iw('h08, rs, rt, lo);     19: w0 = iw('h09, rs, rt, lo);
      20: w0 = iw('h0C, rs, rt, lo);     21: w0 = iw('h0D, rs, rt, lo);
      22: w0 = iw('h0E, rs, rt, lo);     23: w0 = iw('h0A, rs, rt, lo);
      24: w0 = iw('h0B, rs, rt, lo);     25: w0 = iw('h0F, 0, rt, lo);
      26: w0 = iw('h23, rs, rt, lo);     27: w0 = iw('h2B, rs, rt, lo);
      28: w0 = iw('h20, rs, rt, lo);     29: w0 = iw('h24, rs, rt, lo);
      30: w0 = iw('h28, rs, rt, lo);     31: w0 = iw('h04, rs, rt, lo);
      32: w0 = iw('h05, rs, rt, lo);     33: w0 = iw('h06, rs, 0, lo);
      34: w0 = iw('h07, rs, 0, lo);      35: w0 = iw('h01, rs, 0, lo);
      36: w0 = iw('h01, rs, 1, lo);
      37: w0 = (32'h02 << 26) | (imm & 32'h03FF_FFFF);
      38: w0 = (32'h03 << 26) | (imm & 32'h03FF_FFFF);
      39: begin
        w0 = iw('h0F, 0, rt, int'(imm >> 16));
        w1 = iw('h0D, rt, rt, lo);
        return 2;
      end
      default: return 0;
    endcase
    return 1;
  endfunction

  task automatic model_reset();
    pend.delete();
    m_ovalid = 1'b0;
    m_oins   = 32'd0;
    m_oaddr  = 0;
    m_err    = 1'b0;
    m_next   = 0;
  endtask

  task automatic check_outputs();
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_ovalid});
    chk("err", {31'd0, err}, {31'd0, m_err});
    chk("out_ins", out_ins, m_oins);
    chk("out_addr", {28'd0, out_addr}, 32'(m_oaddr));
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model across the edge.
  task automatic cyc(input logic v, input int op, input int rs, input int rt, input int rd,
                     input int sh, input logic [31:0] imm, input logic clr, input logic ordy);
    logic        free, exp_rdy, load, err_n;
    logic [31:0] lw, w0, w1;
    int          n, a;
    in_valid  = v;
    in_op     = 6'(op);
    in_rs     = 5'(rs);
    in_rt     = 5'(rt);
    in_rd     = 5'(rd);
    in_shamt  = 5'(sh);
    in_imm    = imm;
    addr_clr  = clr;
    out_ready = ordy;
    #1;
    check_outputs();
    free    = !m_ovalid || ordy;
    exp_rdy = (pend.size() == 0) && free;
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    load  = 1'b0;
    err_n = 1'b0;
    lw    = 32'd0;
    if (free) begin
      if (pend.size() > 0) begin
        lw   = pend.pop_front();
        load = 1'b1;
      end else if (v) begin
        n = expand(op, rs, rt, rd, sh, imm, w0, w1);
        if (n == 0) err_n = 1'b1;
        else begin
          lw   = w0;
          load = 1'b1;
          if (n == 2) pend.push_back(w1);
        end
      end
    end
    if (load) begin
      a        = clr ? 0 : m_next;
      m_ovalid = 1'b1;
      m_oins   = lw;
      m_oaddr  = a;
      m_next   = (a + 1) % (1 << AW);
    end else begin
      if (ordy) m_ovalid = 1'b0;
      if (clr) m_next = 0;
    end
    m_err = err_n;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 0, 0, 0, 32'd0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    addr_clr  = 1'b0;
    out_ready = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    in_op = 6'd0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_shamt = 5'd0; in_imm = 32'd0;
    do_reset();
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

    // ADDU: one-cycle latency, address 0
    cyc(1'b1, 1, 1, 2, 3, 0, 32'd0, 1'b0, 1'b1);
    chk("addu_ins", out_ins, 32'h00221821);
    chk("addu_addr", {28'd0, out_addr}, 32'd0);
    chk("addu_valid", {31'd0, out_valid}, 32'd1);
    idle(1);

    // LI expansion
    do_reset();
    cyc(1'b1, 39, 0, 8, 0, 0, 32'h12345678, 1'b0, 1'b1);
    chk("li_lui", out_ins, 32'h3C081234);
    chk("li_lui_addr", {28'd0, out_addr}, 32'd0);
    chk("li_lo_ready", {31'd0, in_ready}, 32'd0);
    cyc(1'b1, 0, 1, 1, 1, 0, 32'd0, 1'b0, 1'b1);
    chk("li_ori", out_ins, 32'h35085678);
    chk("li_ori_addr", {28'd0, out_addr}, 32'd1);
    idle(1);

    // JALR and BGEZ
    cyc(1'b1, 17, 4, 0, 5, 0, 32'd0, 1'b0, 1'b1);
    chk("jalr", out_ins, 32'h0080F809);
    cyc(1'b1, 36, 2, 0, 0, 0, 32'h0000FFFF, 1'b0, 1'b1);
    chk("bgez", out_ins, 32'h0441FFFF);
    idle(1);

    // Backpressure: word held stable for 5 cycles, next request waits
    cyc(1'b1, 0, 5, 6, 7, 0, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 2, 9, 10, 11, 0, 32'd0, 1'b0, 1'b0);
      chk("stall_ins", out_ins, 32'h00A63820);
      chk("stall_ready", {31'd0, in_ready}, 32'd0);
    end
    cyc(1'b1, 2, 9, 10, 11, 0, 32'd0, 1'b0, 1'b1);
    idle(2);

    // Illegal op: err pulse, no word, address not advanced
    do_reset();
    cyc(1'b1, 0, 1, 2, 3, 0, 32'd0, 1'b0, 1'b1);
    cyc(1'b1, 45, 1, 2, 3, 0, 32'd0, 1'b0, 1'b1);
    chk("illegal_err", {31'd0, err}, 32'd1);
    chk("illegal_novalid", {31'd0, out_valid}, 32'd0);
    cyc(1'b1, 5, 1, 2, 3, 0, 32'd0, 1'b0, 1'b1);
    chk("illegal_err_pulse", {31'd0, err}, 32'd0);
    chk("after_illegal_addr", {28'd0, out_addr}, 32'd1);
    idle(1);

    // Address wrap at 2^AW, then addr_clr coinciding with a load
    do_reset();
    for (int i = 0; i < 17; i++) begin
      cyc(1'b1, 0, 1, 2, i % 32, 0, 32'd0, 1'b0, 1'b1);
      if (i == 15) chk("wrap_addr15", {28'd0, out_addr}, 32'd15);
    end
    chk("wrap_addr17", {28'd0, out_addr}, 32'd0);
    cyc(1'b1, 0, 3, 3, 3, 0, 32'd0, 1'b1, 1'b1);
    chk("clr_addr0", {28'd0, out_addr}, 32'd0);
    cyc(1'b1, 5, 4, 4, 4, 0, 32'd0, 1'b0, 1'b1);
    chk("clr_addr1", {28'd0, out_addr}, 32'd1);
    idle(1);

    // Reset while the ORI half is pending drops it
    cyc(1'b1, 39, 0, 9, 0, 0, 32'hCAFEBABE, 1'b0, 1'b0);
    cyc(1'b0, 0, 0, 0, 0, 0, 32'd0, 1'b0, 1'b0);
    do_reset();
    idle(3);
    chk("li_reset_novalid", {31'd0, out_valid}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 3) != 0), int'($urandom_range(0, 47)),
          int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
          int'($urandom_range(0, 31)), $urandom(), ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 3) != 0));
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
